// File: rtl/audio_pkg.sv
`default_nettype none
// audio_pkg: shared types and the sample-rate table for the I2S clock path.
package audio_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef logic [1:0] rate_sel_t;

  localparam int TBL_W = 8;

  // clk cycles per BCLK half-period, indexed by rate_sel
  localparam logic [TBL_W-1:0] RATE_HALF [4] = '{8'd16, 8'd32, 8'd48, 8'd64};

endpackage : audio_pkg
`default_nettype wire

// File: rtl/clk_div_toggle.sv
`default_nettype none
// clk_div_toggle: free-running divider; output toggles every DIV/2 input cycles.
module clk_div_toggle #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic clk_out
);

  localparam int HALF = DIV / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  if (DIV < 2 || (DIV % 2) != 0) begin : g_div_chk
    $error("clk_div_toggle: DIV must be even and at least 2");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    out_d = out_q;
    if (cnt_q == LAST) begin
      cnt_d = '0;
      out_d = ~out_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign clk_out = out_q;

endmodule : clk_div_toggle
`default_nettype wire

// File: rtl/i2s_clkgen.sv
`default_nettype none
// i2s_clkgen: I2S master clock generator (MCLK, BCLK, LRCLK, frame strobe).
// Start/stop and rate changes take effect only on frame boundaries.
module i2s_clkgen
  import audio_pkg::*;
#(
  parameter int MCLK_DIV    = 4,
  parameter int BITS_PER_CH = 16,
  parameter int HALF_W      = 8
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      en,
  input  rate_sel_t rate_sel,
  output logic      audio_mclk,
  output logic      audio_clk,
  output logic      audio_lr,
  output logic      frame_start,
  output logic      running
);

  localparam int BCNT_W = $clog2(2 * BITS_PER_CH);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(2 * BITS_PER_CH - 1);
  localparam logic [BCNT_W-1:0] BCNT_MID  = BCNT_W'(BITS_PER_CH);

  for (genvar i = 0; i < 4; i++) begin : g_rate_chk
    if (int'(RATE_HALF[i]) >= (1 << HALF_W)) begin : g_rate_too_wide
      $error("i2s_clkgen: rate table entry does not fit in HALF_W bits");
    end
  end

  clk_div_toggle #(
    .DIV(MCLK_DIV)
  ) u_mclk_div (
    .clk    (clk),
    .reset_n(reset_n),
    .clk_out(audio_mclk)
  );

  state_e              state_q, state_d;
  logic [HALF_W-1:0]   half_q, half_d;
  logic [HALF_W-1:0]   hcnt_q, hcnt_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic                aclk_q, aclk_d;
  logic                lr_q, lr_d;
  logic                fs_q, fs_d;
  logic                run_q, run_d;

  logic [HALF_W-1:0]   half_sel;
  logic                hcnt_tc;
  logic                bclk_fall;
  logic [BCNT_W-1:0]   bcnt_inc;
  logic                frame_end;

  assign half_sel  = HALF_W'(RATE_HALF[rate_sel]);
  assign hcnt_tc   = (hcnt_q == half_q - HALF_W'(1));
  assign bclk_fall = (state_q == RUN) && hcnt_tc && aclk_q;
  assign bcnt_inc  = (bcnt_q == BCNT_LAST) ? '0 : bcnt_q + BCNT_W'(1);
  assign frame_end = bclk_fall && (bcnt_inc == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (frame_end && !en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    half_d = half_q;
    hcnt_d = hcnt_q;
    bcnt_d = bcnt_q;
    aclk_d = aclk_q;
    lr_d   = lr_q;
    run_d  = run_q;
    fs_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        aclk_d = 1'b0;
        lr_d   = 1'b0;
        run_d  = 1'b0;
        hcnt_d = '0;
        bcnt_d = '0;
        if (en) begin
          run_d  = 1'b1;
          fs_d   = 1'b1;
          half_d = half_sel;
        end
      end
      RUN: begin
        if (hcnt_tc) begin
          hcnt_d = '0;
          aclk_d = ~aclk_q;
          // Word clock and frame bookkeeping only move on BCLK falling edges
          if (aclk_q) begin
            bcnt_d = bcnt_inc;
            if (bcnt_inc == BCNT_MID) lr_d = 1'b1;
            if (bcnt_inc == '0) begin
              lr_d = 1'b0;
              if (en) begin
                fs_d   = 1'b1;
                half_d = half_sel;
              end else begin
                run_d = 1'b0;
              end
            end
          end
        end else begin
          hcnt_d = hcnt_q + HALF_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      half_q <= '0;
      hcnt_q <= '0;
      bcnt_q <= '0;
      aclk_q <= 1'b0;
      lr_q   <= 1'b0;
      fs_q   <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      half_q <= half_d;
      hcnt_q <= hcnt_d;
      bcnt_q <= bcnt_d;
      aclk_q <= aclk_d;
      lr_q   <= lr_d;
      fs_q   <= fs_d;
      run_q  <= run_d;
    end
  end

  assign audio_clk   = aclk_q;
  assign audio_lr    = lr_q;
  assign frame_start = fs_q;
  assign running     = run_q;

endmodule : i2s_clkgen
`default_nettype wire

// File: tb/tb_i2s_clkgen.sv
`default_nettype none
// tb_i2s_clkgen: directed plus randomized checks against a frame-timing model.
module tb_i2s_clkgen;

  localparam int BITS = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] rate_sel = 2'd0;
  logic       audio_mclk, audio_clk, audio_lr, frame_start, running;

  int n_checks = 0;
  int n_fail   = 0;

  i2s_clkgen #(
    .MCLK_DIV   (4),
    .BITS_PER_CH(BITS),
    .HALF_W     (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .rate_sel   (rate_sel),
    .audio_mclk (audio_mclk),
    .audio_clk  (audio_clk),
    .audio_lr   (audio_lr),
    .frame_start(frame_start),
    .running    (running)
  );

  always #10 clk = ~clk;

  // Model: a frame is 4*BITS half-periods long; outputs follow from the
  // position inside the frame and the half-period latched at frame start.
  int tbl [4] = '{16, 32, 48, 64};
  int m_n      = 0;
  bit m_active = 1'b0;
  int m_rel    = 0;
  int m_h      = 16;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_n      = 0;
      m_active = 1'b0;
      m_rel    = 0;
    end else begin
      m_n = m_n + 1;
      if (!m_active) begin
        if (en) begin
          m_active = 1'b1;
          m_rel    = 0;
          m_h      = tbl[rate_sel];
        end
      end else if (m_rel + 1 == 4 * BITS * m_h) begin
        if (en) begin
          m_rel = 0;
          m_h   = tbl[rate_sel];
        end else begin
          m_active = 1'b0;
          m_rel    = 0;
        end
      end else begin
        m_rel = m_rel + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic e_clk, e_lr, e_fs, e_run, e_mclk;
    e_mclk = 1'((m_n / 2) % 2);
    e_clk  = m_active ? 1'((m_rel / m_h) % 2) : 1'b0;
    e_lr   = m_active ? (m_rel >= 2 * BITS * m_h) : 1'b0;
    e_fs   = m_active && (m_rel == 0);
    e_run  = m_active;
    check("audio_mclk",  32'(audio_mclk),  32'(e_mclk));
    check("audio_clk",   32'(audio_clk),   32'(e_clk));
    check("audio_lr",    32'(audio_lr),    32'(e_lr));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("running",     32'(running),     32'(e_run));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_outputs();
    end
  endtask

  // Advance until the model sits at frame-relative cycle rel (bounded).
  task automatic wait_rel(input int rel);
    int budget;
    budget = 10000;
    while (!(m_active && m_rel == rel) && budget > 0) begin
      step(1);
      budget--;
    end
    if (budget == 0) check("wait_rel_timeout", 32'(1), 32'(0));
  endtask

  int fs_cnt, lr_rise;
  logic lr_prev;
  int rel_hold;

  initial begin
    // Reset, then idle with en low
    step(3);
    reset_n = 1'b1;
    step(100);

    // Start at rate 0; switch to rate 3 mid-frame
    en = 1'b1;
    rate_sel = 2'd0;
    step(1);
    en = 1'b1;
    wait_rel(300);
    rate_sel = 2'd3;
    wait_rel(0);
    check("rate3_latched", 32'(m_h), 32'd64);
    wait_rel(300);
    rate_sel = 2'd0;
    wait_rel(0);

    // Drop en mid-frame: the frame completes, then the block idles
    wait_rel(700);
    en = 1'b0;
    step(400);
    check("idle_after_stop", 32'(running), 32'd0);
    step(20);
    en = 1'b1;
    step(1);

    // Asynchronous reset mid-frame
    wait_rel(600);
    #3;
    reset_n = 1'b0;
    #1;
    check("rst_clk",  32'(audio_clk),   32'd0);
    check("rst_lr",   32'(audio_lr),    32'd0);
    check("rst_run",  32'(running),     32'd0);
    check("rst_fs",   32'(frame_start), 32'd0);
    check("rst_mclk", 32'(audio_mclk),  32'd0);
    step(3);
    reset_n = 1'b1;
    step(1);
    check("restart_fs", 32'(frame_start), 32'd1);
    en = 1'b0;
    step(1100);
    check("idle_after_reset_frame", 32'(running), 32'd0);

    // Single-cycle en pulse while idle: exactly one frame
    fs_cnt = 0;
    lr_rise = 0;
    lr_prev = 1'b0;
    rate_sel = 2'd0;
    en = 1'b1;
    step(1);
    en = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      if (frame_start) fs_cnt++;
      if (audio_lr && !lr_prev) lr_rise++;
      lr_prev = audio_lr;
      step(1);
    end
    check("pulse_fs_count", 32'(fs_cnt), 32'd1);
    check("pulse_lr_rises", 32'(lr_rise), 32'd1);
    check("pulse_idle", 32'(running), 32'd0);

    // Randomized en and rate activity
    for (int blk = 0; blk < 40; blk++) begin
      rate_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) en = ~en;
      step(int'($urandom_range(50, 400)));
    end
    en = 1'b0;
    step(4200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule : tb_i2s_clkgen
`default_nettype wire
